perceptron_unit: RTL and testbench
==================================

// Module: perceptron_unit
// PURPOSE
// - Parametrised single perceptron neuron: y = act(sum_i w[i]*x[i] + bias) in signed fixed point.
// - Sequential MAC, one product per cycle; runtime-selectable activation; optional on-chip weight update.
// - Sits between the feature-vector source and the classifier/next-layer logic; weights loaded over a write port.
// PARAMETERS
// - N_INPUTS  4   number of inputs / weights (>=1)
// - DATA_W    32  total fixed-point width, signed two's complement
// - FRAC_W    16  fractional bits (< DATA_W - 2); ONE = 1 << FRAC_W
// - GUARD_W   4   extra accumulator MSBs; ACC_W = DATA_W + $clog2(N_INPUTS) + GUARD_W
// PORTS
// - clk        in   1                    clock
// - rst        in   1                    synchronous reset, active-high
// - act_sel    in   2                    act_func code (Step, Sigmoid, Tanh, ReLU), sampled on input accept
// - in_valid   in   1                    input vector valid
// - in_ready   out  1                    unit can accept a vector
// - in_x       in   N_INPUTS*DATA_W      input vector, x[i] = in_x[i*DATA_W +: DATA_W]
// - in_target  in   DATA_W               training target (ignored unless training compiled in)
// - in_train   in   1                    request weight update for this vector
// - w_wr_en    in   1                    weight write strobe
// - w_wr_addr  in   $clog2(N_INPUTS+1)   0..N_INPUTS-1 = w[i], N_INPUTS = bias
// - w_wr_data  in   DATA_W               weight value
// - lr         in   DATA_W               learning rate (fixed point)
// - out_valid  out  1                    result valid, held until accepted
// - out_ready  in   1                    downstream accepts result
// - out_y      out  DATA_W               activation result
// BEHAVIOUR
// - Reset (one clk with rst=1): weights/bias = 0, state Idle, out_valid=0, out_y=0, in_ready=0; in_ready=1 from next cycle.
// - rst mid-operation: abort immediately, return to Idle, in-flight result discarded, weights cleared.
// - States (train_state extended): Idle -> Compute -> Activate -> Output -> [Update] -> Idle.
// - Idle: in_ready = !w_wr_en. Write has priority: no accept in a write cycle. Accept on in_valid&&in_ready:
//   latch x, act_sel, target, in_train; acc <= sign-extended bias.
// - Compute: N_INPUTS cycles, i=0..N-1: acc += (w[i]*x[i]) >>> FRAC_W (2*DATA_W product, arithmetic shift).
// - Activate: 1 cycle; saturate acc to DATA_W (clamp to 0x7F..F / 0x80..0), then act:
//   Step: s>=0 ? ONE : 0 | ReLU: max(s,0) | Tanh: clamp(s,-ONE,ONE) | Sigmoid: clamp((s>>>2)+ONE/2, 0, ONE).
// - Output: out_valid=1, out_y stable until out_valid&&out_ready; latency accept->out_valid = N_INPUTS+2 cycles.
// - w_wr_en outside Idle: ignored (no effect on weights).
// - After output handshake: Update if training compiled in and latched in_train=1, else Idle.
// - Arithmetic results written to weights saturate to DATA_W; no wrap-around anywhere.
// CONFIGURATION
// - PERCEPTRON_TRAIN_EN defined: Update state present. e = target - y (saturated), d = (lr*e)>>>FRAC_W;
//   N_INPUTS cycles w[i] += (d*x[i])>>>FRAC_W, then 1 cycle bias += d; in_ready=0 throughout; then Idle.
// - Not defined: no Update state, in_target/in_train/lr unused, Output always returns to Idle.
// STRUCTURE
// - Shared package: act_func and train_state enums (train_state gains Activate, Output), ONE/saturation
//   constants, parametrised mul-shift and saturate functions.
// - One sub-module: perceptron_act (combinational: saturate + activation select, DATA_W/FRAC_W params).
// TESTING (N_INPUTS=4, DATA_W=32, FRAC_W=16, ONE=0x10000)
// - w=ONE all, bias=0, x={1,2,3,4}.0, ReLU -> out_y=0xA0000, out_valid exactly 6 cycles after accept.
// - w=0x7FFF0000 all, x=ONE all, ReLU -> out_y=0x7FFFFFFF (saturated); w negated -> out_y=0.
// - Step: sum=-ONE -> 0; sum=0 -> 0x10000. Sigmoid: sum=0 -> 0x8000, -ONE -> 0x4000, 4.0 -> 0x10000. Tanh 2.0 -> 0x10000.
// - Backpressure: out_ready=0 for 10 cycles -> out_y stable, in_ready=0, w_wr_en ignored; in_valid with w_wr_en -> no accept.
// - rst asserted mid-Compute -> next cycle out_valid=0, in_ready=1, all weights read back as 0 via recompute.
// - TRAIN_EN: bias=-ONE, w=0, x={1,0,0,0}.0, Step, target=ONE, lr=0x8000 -> y=0; then w[0]=0x8000, bias=0xFFFF8000.

Source files
------------

// File: rtl/perceptron_unit_pkg.sv
// Shared types, fixed-point constants and saturating arithmetic helpers for perceptron_unit.
// The Update state is only reached when PERCEPTRON_TRAIN_EN is defined.
package perceptron_unit_pkg;

   // Wide enough for any DATA_W x DATA_W product with DATA_W up to 63
   localparam int MATH_W = 128;

   typedef logic signed [MATH_W-1:0] wide_t;

   typedef enum logic [1:0] {
      ACT_STEP    = 2'd0,
      ACT_SIGMOID = 2'd1,
      ACT_TANH    = 2'd2,
      ACT_RELU    = 2'd3
   } act_func_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_COMPUTE  = 3'd1,
      ST_ACTIVATE = 3'd2,
      ST_OUTPUT   = 3'd3,
      ST_UPDATE   = 3'd4
   } train_state_t;

   function automatic wide_t fx_one(input int unsigned frac_w);
      return wide_t'(1'b1) <<< frac_w;
   endfunction

   function automatic wide_t sat_max(input int unsigned w);
      return (wide_t'(1'b1) <<< (w - 32'd1)) - wide_t'(1'b1);
   endfunction

   function automatic wide_t sat_min(input int unsigned w);
      return -sat_max(w) - wide_t'(1'b1);
   endfunction

   function automatic wide_t clamp(input wide_t v, input wide_t lo, input wide_t hi);
      wide_t r;
      if (v > hi) begin
         r = hi;
      end else if (v < lo) begin
         r = lo;
      end else begin
         r = v;
      end
      return r;
   endfunction

   function automatic wide_t sat_w(input wide_t v, input int unsigned w);
      return clamp(v, sat_min(w), sat_max(w));
   endfunction

   function automatic wide_t mul_shift(input wide_t a, input wide_t b, input int unsigned frac_w);
      return (a * b) >>> frac_w;
   endfunction

endpackage

// File: rtl/perceptron_unit_act.sv
// perceptron_act: combinational output stage. Saturates the accumulator to DATA_W and
// applies the selected activation (step, piecewise sigmoid, hard tanh, ReLU).
module perceptron_act
   import perceptron_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int FRAC_W = 16,
   parameter int ACC_W  = 38
) (
   input  logic signed [ACC_W-1:0]  acc,
   input  logic        [1:0]        act_sel,
   output logic signed [DATA_W-1:0] y
);

   wide_t zero_s;
   wide_t one_s;
   wide_t s_s;
   wide_t res_s;

   // Saturate to the output width, then pick the activation
   always_comb begin
      zero_s = wide_t'(1'b0);
      one_s  = fx_one(FRAC_W);
      s_s    = sat_w(wide_t'(acc), DATA_W);
      case (act_func_t'(act_sel))
         ACT_STEP:    res_s = (s_s >= zero_s) ? one_s : zero_s;
         ACT_SIGMOID: res_s = clamp((s_s >>> 32'd2) + (one_s >>> 32'd1), zero_s, one_s);
         ACT_TANH:    res_s = clamp(s_s, -one_s, one_s);
         ACT_RELU:    res_s = (s_s < zero_s) ? zero_s : s_s;
         default:     res_s = zero_s;
      endcase
      y = DATA_W'(res_s);
   end

endmodule

// File: rtl/perceptron_unit.sv
// perceptron_unit: single fixed-point neuron with a sequential MAC and selectable activation.
// Define PERCEPTRON_TRAIN_EN to build the on-chip weight-update pass.
module perceptron_unit
   import perceptron_unit_pkg::*;
#(
   parameter int N_INPUTS = 4,
   parameter int DATA_W   = 32,
   parameter int FRAC_W   = 16,
   parameter int GUARD_W  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [1:0]                    act_sel,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [N_INPUTS*DATA_W-1:0]    in_x,
   input  logic [DATA_W-1:0]             in_target,
   input  logic                          in_train,
   input  logic                          w_wr_en,
   input  logic [$clog2(N_INPUTS+1)-1:0] w_wr_addr,
   input  logic [DATA_W-1:0]             w_wr_data,
   input  logic [DATA_W-1:0]             lr,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_W-1:0]             out_y
);

   localparam int ACC_W  = DATA_W + $clog2(N_INPUTS) + GUARD_W;
   localparam int ADDR_W = $clog2(N_INPUTS + 1);
   localparam int IDX_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

   train_state_t             state_r;
   logic signed [DATA_W-1:0] w_r [N_INPUTS];
   logic signed [DATA_W-1:0] x_r [N_INPUTS];
   logic signed [DATA_W-1:0] bias_r;
   logic [1:0]               act_r;
   logic signed [ACC_W-1:0]  acc_r;
   logic [ADDR_W-1:0]        idx_r;
   logic                     out_valid_r;
   logic signed [DATA_W-1:0] out_y_r;
   logic signed [DATA_W-1:0] act_y_s;
   logic [IDX_W-1:0]         sel_s;
   wide_t                    acc_next_s;

   assign sel_s = IDX_W'(idx_r);

   // One multiply-accumulate step for the weight selected by idx_r
   always_comb begin
      acc_next_s = sat_w(wide_t'(acc_r)
                         + mul_shift(wide_t'(w_r[sel_s]), wide_t'(x_r[sel_s]), FRAC_W), ACC_W);
   end

`ifdef PERCEPTRON_TRAIN_EN
   logic signed [DATA_W-1:0] target_r;
   logic signed [DATA_W-1:0] d_r;
   logic                     train_r;
   wide_t                    d_s;
   wide_t                    w_upd_s;
   wide_t                    b_upd_s;

   // Scaled error and saturated candidates for the weight/bias update pass
   always_comb begin
      d_s     = sat_w(mul_shift(wide_t'(signed'(lr)),
                                sat_w(wide_t'(target_r) - wide_t'(out_y_r), DATA_W), FRAC_W), DATA_W);
      w_upd_s = sat_w(wide_t'(w_r[sel_s])
                      + mul_shift(wide_t'(d_r), wide_t'(x_r[sel_s]), FRAC_W), DATA_W);
      b_upd_s = sat_w(wide_t'(bias_r) + wide_t'(d_r), DATA_W);
   end
`else
   logic unused_s;
   assign unused_s = ^{in_target, in_train, lr};
`endif

   // Sequencer: accept, MAC over N_INPUTS cycles, activate, hold output, optional update
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         bias_r      <= {DATA_W{1'b0}};
         act_r       <= 2'd0;
         acc_r       <= {ACC_W{1'b0}};
         idx_r       <= {ADDR_W{1'b0}};
         out_valid_r <= 1'b0;
         out_y_r     <= {DATA_W{1'b0}};
         for (int i = 0; i < N_INPUTS; i++) begin
            w_r[i] <= {DATA_W{1'b0}};
            x_r[i] <= {DATA_W{1'b0}};
         end
`ifdef PERCEPTRON_TRAIN_EN
         target_r <= {DATA_W{1'b0}};
         d_r      <= {DATA_W{1'b0}};
         train_r  <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               // A weight write wins over an input vector in the same cycle
               if (w_wr_en) begin
                  if (w_wr_addr == ADDR_W'(N_INPUTS)) begin
                     bias_r <= w_wr_data;
                  end else if (w_wr_addr < ADDR_W'(N_INPUTS)) begin
                     w_r[IDX_W'(w_wr_addr)] <= w_wr_data;
                  end
               end else if (in_valid) begin
                  for (int i = 0; i < N_INPUTS; i++) begin
                     x_r[i] <= in_x[i*DATA_W +: DATA_W];
                  end
                  act_r   <= act_sel;
                  acc_r   <= ACC_W'(bias_r);
                  idx_r   <= {ADDR_W{1'b0}};
                  state_r <= ST_COMPUTE;
`ifdef PERCEPTRON_TRAIN_EN
                  target_r <= in_target;
                  train_r  <= in_train;
`endif
               end
            end
            ST_COMPUTE: begin
               acc_r <= ACC_W'(acc_next_s);
               if (idx_r == ADDR_W'(N_INPUTS - 1)) begin
                  idx_r   <= {ADDR_W{1'b0}};
                  state_r <= ST_ACTIVATE;
               end else begin
                  idx_r <= idx_r + ADDR_W'(1'b1);
               end
            end
            ST_ACTIVATE: begin
               out_y_r     <= act_y_s;
               out_valid_r <= 1'b1;
               state_r     <= ST_OUTPUT;
            end
            ST_OUTPUT: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
`ifdef PERCEPTRON_TRAIN_EN
                  if (train_r) begin
                     d_r     <= DATA_W'(d_s);
                     idx_r   <= {ADDR_W{1'b0}};
                     state_r <= ST_UPDATE;
                  end else begin
                     state_r <= ST_IDLE;
                  end
`else
                  state_r <= ST_IDLE;
`endif
               end
            end
`ifdef PERCEPTRON_TRAIN_EN
            ST_UPDATE: begin
               // Weights first, bias on the final pass
               if (idx_r == ADDR_W'(N_INPUTS)) begin
                  bias_r  <= DATA_W'(b_upd_s);
                  state_r <= ST_IDLE;
               end else begin
                  w_r[sel_s] <= DATA_W'(w_upd_s);
                  idx_r      <= idx_r + ADDR_W'(1'b1);
               end
            end
`endif
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   perceptron_act #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
   ) u_act (
      .acc     (acc_r),
      .act_sel (act_r),
      .y       (act_y_s)
   );

   assign in_ready  = (state_r == ST_IDLE) && !w_wr_en && !rst;
   assign out_valid = out_valid_r;
   assign out_y     = out_y_r;

endmodule

// File: tb/tb_perceptron_unit.sv
// Scoreboard bench for perceptron_unit: directed spec cases plus randomized vectors
// checked against a plain-arithmetic reference neuron.
module tb_perceptron_unit;

   localparam int N   = 4;
   localparam int DW  = 32;
   localparam int AW  = $clog2(N + 1);
   localparam int ONE = 32'h0001_0000;
   localparam int A_STEP = 0, A_SIGMOID = 1, A_TANH = 2, A_RELU = 3;
   localparam longint I32_MAX = 64'sd2147483647;
   localparam longint I32_MIN = -64'sd2147483648;
   localparam longint ACC_MAX = (64'sd1 <<< 37) - 64'sd1;
   localparam longint ACC_MIN = -(64'sd1 <<< 37);

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    act_sel;
   logic          in_valid;
   logic          in_ready;
   logic [N*DW-1:0] in_x;
   logic [DW-1:0] in_target;
   logic          in_train;
   logic          w_wr_en;
   logic [AW-1:0] w_wr_addr;
   logic [DW-1:0] w_wr_data;
   logic [DW-1:0] lr;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_y;

   int vectors = 0;
   int miscompares = 0;
   int q_exp[$];
   int vx[N];
   int mw[N];
   int mb;

   perceptron_unit dut (
      .clk(clk), .rst(rst), .act_sel(act_sel), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_target(in_target), .in_train(in_train), .w_wr_en(w_wr_en),
      .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data), .lr(lr), .out_valid(out_valid),
      .out_ready(out_ready), .out_y(out_y)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
      end
   endtask

   function automatic longint clampl(input longint v, input longint lo, input longint hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Reference neuron: bias plus fixed-point dot product, then saturate and activate
   function automatic int model_eval(input int act);
      longint acc, s, r;
      acc = mb;
      for (int i = 0; i < N; i++)
         acc = clampl(acc + ((longint'(mw[i]) * longint'(vx[i])) >>> 16), ACC_MIN, ACC_MAX);
      s = clampl(acc, I32_MIN, I32_MAX);
      case (act)
         A_STEP:    r = (s >= 0) ? ONE : 0;
         A_SIGMOID: r = clampl((s >>> 2) + ONE / 2, 0, ONE);
         A_TANH:    r = clampl(s, -ONE, ONE);
         default:   r = (s < 0) ? 0 : s;
      endcase
      return int'(r);
   endfunction

   function automatic void model_train(input int y, input int target);
      longint e, d;
      e = clampl(longint'(target) - longint'(y), I32_MIN, I32_MAX);
      d = clampl((longint'(int'(lr)) * e) >>> 16, I32_MIN, I32_MAX);
      for (int i = 0; i < N; i++)
         mw[i] = int'(clampl(longint'(mw[i]) + ((d * longint'(vx[i])) >>> 16), I32_MIN, I32_MAX));
      mb = int'(clampl(longint'(mb) + d, I32_MIN, I32_MAX));
   endfunction

   function automatic int rand_fx();
      if ($urandom_range(0, 7) == 0) return int'($urandom);
      return int'($urandom_range(0, 8 * ONE)) - 4 * ONE;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL idle_timeout: in_ready 0 after %0d cycles, required 1", n);
      end
   endtask

   task automatic write_w(input int addr, input int data);
      wait_idle();
      tick();
      w_wr_en   = 1'b1;
      w_wr_addr = addr[AW-1:0];
      w_wr_data = data;
      tick();
      w_wr_en = 1'b0;
      if (addr < N) mw[addr] = data;
      else if (addr == N) mb = data;
   endtask

   task automatic set_x(input int a, input int b, input int c, input int d);
      vx[0] = a; vx[1] = b; vx[2] = c; vx[3] = d;
   endtask

   task automatic set_w_all(input int v);
      for (int i = 0; i < N; i++) write_w(i, v);
   endtask

   // Issue one vector, push its expected result, check accept and latency
   task automatic issue(input int act, input bit train, input int target, input int expv);
      int cnt;
      wait_idle();
      q_exp.push_back(expv);
      tick();
      for (int i = 0; i < N; i++) in_x[i*DW +: DW] = vx[i];
      act_sel   = act[1:0];
      in_train  = train;
      in_target = target;
      in_valid  = 1'b1;
      @(negedge clk);
      check("accept_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid  = 1'b0;
      act_sel   = ~act_sel;
      in_x      = {$urandom, $urandom, $urandom, $urandom};
      in_target = $urandom;
      in_train  = ~in_train;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!out_valid && cnt < 40);
      check("latency", cnt, N + 2);
`ifdef PERCEPTRON_TRAIN_EN
      if (train) model_train(expv, target);
`endif
   endtask

   // Scoreboard monitor: pop an expectation on every output handshake
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (q_exp.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_output: out_y=0x%08h with no result pending", out_y);
         end else begin
            check("result", out_y, q_exp.pop_front());
         end
      end
   end

   initial begin
      int a, hold_exp, seen;
      rst = 1'b1; act_sel = 2'd0; in_valid = 1'b0; in_x = '0; in_target = '0; in_train = 1'b0;
      w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0; lr = 32'h0000_8000; out_ready = 1'b1;
      for (int i = 0; i < N; i++) begin mw[i] = 0; vx[i] = 0; end
      mb = 0;
      tick(); tick();
      @(negedge clk);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_out_y", out_y, 32'd0);
      check("reset_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

      set_w_all(ONE); write_w(N, 0);
      set_x(ONE, 2 * ONE, 3 * ONE, 4 * ONE);
      issue(A_RELU, 1'b0, 0, 32'h000A_0000);

      set_w_all(32'h7FFF_0000);
      set_x(ONE, ONE, ONE, ONE);
      issue(A_RELU, 1'b0, 0, 32'h7FFF_FFFF);
      set_w_all(-32'sh7FFF_0000);
      issue(A_RELU, 1'b0, 0, 0);

      set_w_all(0);
      write_w(N, -ONE); issue(A_STEP, 1'b0, 0, 0);
      write_w(N, 0);    issue(A_STEP, 1'b0, 0, ONE);
      issue(A_SIGMOID, 1'b0, 0, 32'h0000_8000);
      write_w(N, -ONE); issue(A_SIGMOID, 1'b0, 0, 32'h0000_4000);
      write_w(N, 4 * ONE); issue(A_SIGMOID, 1'b0, 0, ONE);
      write_w(N, 2 * ONE); issue(A_TANH, 1'b0, 0, ONE);

      // Backpressure: result held, no input accept, weight writes ignored
      for (int i = 0; i <= N; i++) write_w(i, rand_fx());
      for (int i = 0; i < N; i++) vx[i] = rand_fx();
      a = $urandom_range(0, 3);
      hold_exp = model_eval(a);
      out_ready = 1'b0;
      issue(a, 1'b0, 0, hold_exp);
      for (int k = 0; k < 10; k++) begin
         tick();
         w_wr_en = 1'b1; w_wr_addr = '0; w_wr_data = 32'h0123_4567;
         @(negedge clk);
         check("hold_valid", {31'd0, out_valid}, 32'd1);
         check("hold_y", out_y, hold_exp);
         check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      tick();
      w_wr_en = 1'b0;
      out_ready = 1'b1;
      issue(a, 1'b0, 0, model_eval(a));

      // Write and input valid together: write lands, vector dropped
      wait_idle();
      tick();
      in_valid = 1'b1; w_wr_en = 1'b1; w_wr_addr = N[AW-1:0]; w_wr_data = ONE;
      @(negedge clk);
      check("write_blocks_accept", {31'd0, in_ready}, 32'd0);
      tick();
      in_valid = 1'b0; w_wr_en = 1'b0;
      mb = ONE;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("no_accept_output", seen, 0);
      issue(A_TANH, 1'b0, 0, model_eval(A_TANH));

      for (int k = 0; k < 24; k++) begin
         if (k % 4 == 0) for (int i = 0; i <= N; i++) write_w(i, rand_fx());
         for (int i = 0; i < N; i++) vx[i] = rand_fx();
         a = $urandom_range(0, 3);
         issue(a, 1'b0, 0, model_eval(a));
      end

`ifdef PERCEPTRON_TRAIN_EN
      set_w_all(0); write_w(N, -ONE);
      set_x(ONE, 0, 0, 0);
      lr = 32'h0000_8000;
      issue(A_STEP, 1'b1, ONE, 0);
      set_x(2 * ONE, 0, 0, 0);
      issue(A_RELU, 1'b0, 0, 32'h0000_8000);
      set_x(0, 0, 0, 0);
      issue(A_TANH, 1'b0, 0, 32'hFFFF_8000);
      for (int k = 0; k < 12; k++) begin
         for (int i = 0; i < N; i++) vx[i] = rand_fx();
         lr = $urandom_range(0, ONE);
         a = $urandom_range(0, 3);
         issue(a, 1'($urandom_range(0, 1)), rand_fx(), model_eval(a));
      end
      issue(A_TANH, 1'b0, 0, model_eval(A_TANH));
`endif

      // Reset in the middle of Compute: result discarded, weights cleared
      for (int i = 0; i <= N; i++) write_w(i, rand_fx());
      wait_idle();
      tick();
      set_x(ONE, 2 * ONE, 3 * ONE, 4 * ONE);
      for (int i = 0; i < N; i++) in_x[i*DW +: DW] = vx[i];
      act_sel = 2'(A_RELU); in_train = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < N; i++) mw[i] = 0;
      mb = 0;
      @(negedge clk);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check("abort_out_y", out_y, 32'd0);
      issue(A_SIGMOID, 1'b0, 0, 32'h0000_8000);

      repeat (4) @(negedge clk);
      check("queue_drained", q_exp.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
